// File: rtl/operand_controller.sv
// Operand fetch controller: reads vrs1, vrs2, vrs3, vrs3+1 from the register file and presents A/B/C plus opcode for one cycle.
// Define OPCTRL_BACK2BACK_EN to accept the next uinstr in DONE, removing the idle cycle between operations.
module operand_controller #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int OPCODE_W = 4
) (
  input  logic                         clk_i,
  input  logic                         arst_ni,
  input  logic [OPCODE_W+3*ADDR_W-1:0] uinstr_i,
  input  logic                         uinstr_valid_i,
  output logic                         uinstr_ready_o,
  output logic [ADDR_W-1:0]            rd_addr_o,
  output logic                         rd_addr_valid_o,
  input  logic                         rd_addr_ready_i,
  input  logic [DATA_W-1:0]            rd_data_i,
  input  logic                         rd_data_valid_i,
  output logic [DATA_W-1:0]            operand_a_o,
  output logic [DATA_W-1:0]            operand_b_o,
  output logic [2*DATA_W-1:0]          operand_c_o,
  output logic [OPCODE_W-1:0]          operation_code_o,
  output logic                         operation_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [OPCODE_W-1:0]  r_opcode;
  logic [ADDR_W-1:0]    r_vrs1;
  logic [ADDR_W-1:0]    r_vrs2;
  logic [ADDR_W-1:0]    r_vrs3;
  logic [2:0]           r_addr_cnt;
  logic [2:0]           r_data_cnt;
  logic [DATA_W-1:0]    r_op_a;
  logic [DATA_W-1:0]    r_op_b;
  logic [2*DATA_W-1:0]  r_op_c;
  logic [OPCODE_W-1:0]  r_op_code;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_addr_valid;
  logic                 w_addr_hs;
  logic                 w_data_take;
  logic                 w_last_word;
  logic [ADDR_W-1:0]    w_addr;

  assign w_accept     = uinstr_valid_i && w_ready;
  assign w_addr_valid = (r_state == S_FETCH) && (r_addr_cnt < 3'd4);
  assign w_addr_hs    = w_addr_valid && rd_addr_ready_i;
  // Data outside FETCH or past the 4th word is ignored; the counter saturates at 4.
  assign w_data_take  = (r_state == S_FETCH) && rd_data_valid_i && (r_data_cnt < 3'd4);
  assign w_last_word  = w_data_take && (r_data_cnt == 3'd3);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_addr = '0;
    case (r_addr_cnt)
      3'd0:    w_addr = r_vrs1;
      3'd1:    w_addr = r_vrs2;
      3'd2:    w_addr = r_vrs3;
      3'd3:    w_addr = r_vrs3 + ADDR_W'(1);
      default: w_addr = '0;
    endcase
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_ready           = 1'b0;
    operation_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (uinstr_valid_i) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_last_word) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        operation_valid_o = 1'b1;
`ifdef OPCTRL_BACK2BACK_EN
        w_ready     = 1'b1;
        w_state_nxt = uinstr_valid_i ? S_FETCH : S_IDLE;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state    <= S_IDLE;
      r_opcode   <= '0;
      r_vrs1     <= '0;
      r_vrs2     <= '0;
      r_vrs3     <= '0;
      r_addr_cnt <= '0;
      r_data_cnt <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_c     <= '0;
      r_op_code  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_opcode   <= uinstr_i[OPCODE_W+3*ADDR_W-1 -: OPCODE_W];
        r_vrs1     <= uinstr_i[3*ADDR_W-1 -: ADDR_W];
        r_vrs2     <= uinstr_i[2*ADDR_W-1 -: ADDR_W];
        r_vrs3     <= uinstr_i[ADDR_W-1:0];
        r_addr_cnt <= '0;
        r_data_cnt <= '0;
      end else begin
        if (w_addr_hs) r_addr_cnt <= r_addr_cnt + 3'd1;
        if (w_data_take) begin
          r_data_cnt <= r_data_cnt + 3'd1;
          case (r_data_cnt[1:0])
            2'd0: r_op_a                   <= rd_data_i;
            2'd1: r_op_b                   <= rd_data_i;
            2'd2: r_op_c[2*DATA_W-1:DATA_W] <= rd_data_i;
            default: r_op_c[DATA_W-1:0]    <= rd_data_i;
          endcase
        end
        if (w_last_word) r_op_code <= r_opcode;
      end
    end
  end

  assign uinstr_ready_o   = w_ready;
  assign rd_addr_o        = w_addr;
  assign rd_addr_valid_o  = w_addr_valid;
  assign operand_a_o      = r_op_a;
  assign operand_b_o      = r_op_b;
  assign operand_c_o      = r_op_c;
  assign operation_code_o = r_op_code;

endmodule

// File: tb/tb_operand_controller.sv
// Directed bench for operand_controller: a small register-file responder returns data one cycle after each address handshake.
module tb_operand_controller;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [15:0] uinstr_i;
  logic        uinstr_valid_i;
  logic        uinstr_ready_o;
  logic [3:0]  rd_addr_o;
  logic        rd_addr_valid_o;
  logic        rd_addr_ready_i;
  logic [3:0]  rd_data_i;
  logic        rd_data_valid_i;
  logic [3:0]  operand_a_o;
  logic [3:0]  operand_b_o;
  logic [7:0]  operand_c_o;
  logic [3:0]  operation_code_o;
  logic        operation_valid_o;

  operand_controller #(.ADDR_W(4), .DATA_W(4), .OPCODE_W(4)) dut (
    .clk_i             (clk_i),
    .arst_ni           (arst_ni),
    .uinstr_i          (uinstr_i),
    .uinstr_valid_i    (uinstr_valid_i),
    .uinstr_ready_o    (uinstr_ready_o),
    .rd_addr_o         (rd_addr_o),
    .rd_addr_valid_o   (rd_addr_valid_o),
    .rd_addr_ready_i   (rd_addr_ready_i),
    .rd_data_i         (rd_data_i),
    .rd_data_valid_i   (rd_data_valid_i),
    .operand_a_o       (operand_a_o),
    .operand_b_o       (operand_b_o),
    .operand_c_o       (operand_c_o),
    .operation_code_o  (operation_code_o),
    .operation_valid_o (operation_valid_o)
  );

  always #5 clk_i = ~clk_i;

  logic [3:0] mem [16];
  logic [3:0] addr_log [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_pulse  = 0;
  int         n_accept = 0;
  int         n_data   = 0;
  bit         hold_valid = 1'b0;
  logic [3:0] cap_a, cap_b, cap_code;
  logic [7:0] cap_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs sampled at the falling edge, responder and monitors updated 1 time unit after the rising edge.
  task automatic tick();
    logic       hs;
    logic       acc;
    logic [3:0] a;
    @(negedge clk_i);
    hs  = rd_addr_valid_o && rd_addr_ready_i;
    a   = rd_addr_o;
    acc = uinstr_valid_i && uinstr_ready_o;
    @(posedge clk_i);
    #1;
    rd_data_valid_i = hs;
    rd_data_i       = hs ? mem[a] : 4'h0;
    if (hs) begin
      addr_log.push_back(a);
      n_data++;
    end
    if (acc) begin
      n_accept++;
      if (!hold_valid) uinstr_valid_i = 1'b0;
    end
    if (operation_valid_o) begin
      n_pulse++;
      cap_a    = operand_a_o;
      cap_b    = operand_b_o;
      cap_c    = operand_c_o;
      cap_code = operation_code_o;
    end
  endtask

  task automatic check_addrs(input string tag, input logic [15:0] exp);
    check({tag, " nreads"}, addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check({tag, " addr"}, (i < addr_log.size()) ? addr_log[i] : 4'hx, exp[15-4*i -: 4]);
  endtask

  task automatic run_op(input string tag, input logic [15:0] instr, input logic [15:0] exp_addrs,
                        input logic [3:0] exp_a, input logic [3:0] exp_b, input logic [7:0] exp_c,
                        input logic [3:0] exp_code, input bit stall);
    int p0;
    bit stalled;
    p0       = n_pulse;
    stalled  = 1'b0;
    addr_log.delete();
    uinstr_i       = instr;
    uinstr_valid_i = 1'b1;
    for (int i = 0; i < 60 && n_pulse == p0; i++) begin
      if (stall && !stalled && addr_log.size() == 1) begin
        rd_addr_ready_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check({tag, " stall addr"}, rd_addr_o, exp_addrs[11:8]);
          check({tag, " stall valid"}, rd_addr_valid_o, 1'b1);
        end
        check({tag, " stall reads"}, addr_log.size(), 1);
        rd_addr_ready_i = 1'b1;
        stalled = 1'b1;
      end
      tick();
    end
    check({tag, " pulse"}, n_pulse - p0, 1);
    check_addrs(tag, exp_addrs);
    check({tag, " a"}, cap_a, exp_a);
    check({tag, " b"}, cap_b, exp_b);
    check({tag, " c"}, cap_c, exp_c);
    check({tag, " code"}, cap_code, exp_code);
    tick();
    check({tag, " pulse width"}, operation_valid_o, 1'b0);
    check({tag, " ready after"}, uinstr_ready_o, 1'b1);
    check({tag, " a held"}, operand_a_o, exp_a);
    check({tag, " c held"}, operand_c_o, exp_c);
  endtask

  initial begin
    int p0;
    int a0;
    int d0;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    mem[0] = 4'h6; mem[1] = 4'h3; mem[2] = 4'h9; mem[3] = 4'h2;
    mem[4] = 4'h5; mem[5] = 4'hD; mem[6] = 4'h1; mem[7] = 4'hA;
    mem[8] = 4'hC; mem[15] = 4'hE;

    arst_ni         = 1'b0;
    uinstr_i        = '0;
    uinstr_valid_i  = 1'b0;
    rd_addr_ready_i = 1'b1;
    rd_data_i       = '0;
    rd_data_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst op_valid", operation_valid_o, 1'b0);
    check("rst addr_valid", rd_addr_valid_o, 1'b0);
    check("rst ready", uinstr_ready_o, 1'b1);
    check("rst a", operand_a_o, 4'h0);
    check("rst b", operand_b_o, 4'h0);
    check("rst c", operand_c_o, 8'h00);
    check("rst code", operation_code_o, 4'h0);
    check("rst addr", rd_addr_o, 4'h0);
    @(negedge clk_i);
    arst_ni = 1'b1;
    tick();

    run_op("basic", 16'h5127, 16'h1278, 4'h3, 4'h9, 8'hAC, 4'h5, 1'b0);
    run_op("stall", 16'h3456, 16'h4567, 4'h5, 4'hD, 8'h1A, 4'h3, 1'b1);
    run_op("wrap",  16'h912F, 16'h12F0, 4'h3, 4'h9, 8'hE6, 4'h9, 1'b0);

    // Busy: valid held high across two uinstrs; the second is taken only after the first pulse.
    p0 = n_pulse;
    a0 = n_accept;
    addr_log.delete();
    hold_valid     = 1'b1;
    uinstr_i       = 16'hA012;
    uinstr_valid_i = 1'b1;
    for (int i = 0; i < 60 && n_pulse == p0; i++) begin
      tick();
      if (n_accept == a0 + 1 && n_pulse == p0) begin
        uinstr_i = 16'hB87F;
        check("busy ready", uinstr_ready_o, 1'b0);
      end
    end
    check("busy pulse1", n_pulse - p0, 1);
    check("busy accepts1", n_accept - a0, 1);
    check("busy a1", cap_a, 4'h6);
    check("busy b1", cap_b, 4'h3);
    check("busy c1", cap_c, 8'h92);
    check("busy code1", cap_code, 4'hA);
    for (int i = 0; i < 60 && n_pulse == p0 + 1; i++) begin
      tick();
      if (n_accept == a0 + 2) begin
        hold_valid     = 1'b0;
        uinstr_valid_i = 1'b0;
      end
    end
    check("busy pulse2", n_pulse - p0, 2);
    check("busy accepts2", n_accept - a0, 2);
    check("busy reads", addr_log.size(), 8);
    check("busy a2", cap_a, 4'hC);
    check("busy b2", cap_b, 4'hA);
    check("busy c2", cap_c, 8'hE6);
    check("busy code2", cap_code, 4'hB);
    tick();

    // Abort: reset after two data words have been captured.
    p0 = n_pulse;
    d0 = n_data;
    uinstr_i       = 16'h7456;
    uinstr_valid_i = 1'b1;
    for (int i = 0; i < 30 && n_data < d0 + 2; i++) tick();
    check("abort words", n_data - d0, 2);
    tick();
    arst_ni         = 1'b0;
    rd_data_valid_i = 1'b0;
    uinstr_valid_i  = 1'b0;
    #1;
    check("abort op_valid", operation_valid_o, 1'b0);
    check("abort addr_valid", rd_addr_valid_o, 1'b0);
    check("abort ready", uinstr_ready_o, 1'b1);
    check("abort a cleared", operand_a_o, 4'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    arst_ni = 1'b1;
    repeat (4) tick();
    check("abort no pulse", n_pulse - p0, 0);
    run_op("post", 16'h2127, 16'h1278, 4'h3, 4'h9, 8'hAC, 4'h2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
